// File: rtl/snes_pad_sniffer_pkg.sv
// Shared constants for the SNES pad sniffer: FSM encodings, frame geometry, button combos.
// PAD_REGION_COMBO_EN adds the region-override combo constant.
package snes_pad_sniffer_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLatch = 2'd1;
  localparam logic [1:0] StShift = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam int unsigned FrameBits = 16;
  localparam logic [3:0]  IdStd     = 4'h0;

  // L+R+Select+Start
  localparam logic [11:0] ComboRst = 12'h0C0C;
`ifdef PAD_REGION_COMBO_EN
  // L+R+Select+Y
  localparam logic [11:0] ComboRegion = 12'h0C06;
`endif

  function automatic logic combo_hit(input logic [15:0] pad, input logic [11:0] combo);
    return pad[11:0] == combo;
  endfunction

endpackage

// File: rtl/snes_pad_sniffer_pad_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pad-port line, plus rise/fall detect
// on the synchronized level.
module snes_pad_sniffer_pad_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_i};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/snes_pad_sniffer.sv
// Passive SNES controller-port tap: rebuilds 16-bit frames, validates the ID nibble and
// detects held button combos. Define PAD_REGION_COMBO_EN for the region-toggle combo.
module snes_pad_sniffer
  import snes_pad_sniffer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input  logic        CLK_i,
  input  logic        NRST_i,
  input  logic        CTRL_LATCH_i,
  input  logic        CTRL_CLK_i,
  input  logic        CTRL_SDATA_i,
  output logic [15:0] pad_o,
  output logic        pad_valid_o,
  output logic        frame_err_o,
  output logic        REQ_RST_o,
  output logic        FORCE_REGION_o
);

  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYC);
  localparam int unsigned HoldW = $clog2(HOLD_FRAMES + 1);

  logic latch_rise, latch_fall, pclk_rise, pclk_fall;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic data_s;

  logic [1:0]      state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [15:0]     shift_q, shift_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [15:0]     pad_q, pad_d;
  logic            pad_valid_q, pad_valid_d;
  logic            frame_err_q, frame_err_d;

  logic [HoldW-1:0] rst_hold_q, rst_hold_d;
  logic             rst_armed_q, rst_armed_d;
  logic             req_rst_q, req_rst_d;

  snes_pad_sniffer_pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk_i  (CLK_i),
    .rst_ni (NRST_i),
    .d_i    (CTRL_LATCH_i),
    .rise_o (latch_rise),
    .fall_o (latch_fall)
  );

  snes_pad_sniffer_pad_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk_i  (CLK_i),
    .rst_ni (NRST_i),
    .d_i    (CTRL_CLK_i),
    .rise_o (pclk_rise),
    .fall_o (pclk_fall)
  );

  // Same depth as the edge chains so data is sampled in step with the detected edge.
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], CTRL_SDATA_i};
  assign data_s      = data_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tmo_d       = '0;
    pad_d       = pad_q;
    pad_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      StIdle: if (latch_rise) state_d = StLatch;
      StLatch: begin
        if (latch_rise) begin
          frame_err_d = 1'b1;
        end else if (latch_fall) begin
          shift_d = {15'd0, ~data_s};
          cnt_d   = 5'd1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (latch_rise) begin
          frame_err_d = 1'b1;
          state_d     = StLatch;
        end else if (cnt_q == 5'(FrameBits)) begin
          state_d = StDone;
        end else if (tmo_q == TmoW'(TIMEOUT_CYC - 1)) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          if (pclk_rise) begin
            shift_d[cnt_q[3:0]] = ~data_s;
            cnt_d               = cnt_q + 5'd1;
          end
          tmo_d = (pclk_rise | pclk_fall) ? '0 : tmo_q + TmoW'(1);
        end
      end
      default: begin
        if (shift_q[15:12] == IdStd) begin
          pad_d       = shift_q;
          pad_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d = latch_rise ? StLatch : StIdle;
      end
    endcase
  end

  always_comb begin
    rst_hold_d  = rst_hold_q;
    rst_armed_d = rst_armed_q;
    req_rst_d   = 1'b0;
    if (pad_valid_d) begin
      if (combo_hit(pad_d, ComboRst)) begin
        if (rst_hold_q < HoldW'(HOLD_FRAMES)) rst_hold_d = rst_hold_q + HoldW'(1);
        if (rst_armed_q && rst_hold_d == HoldW'(HOLD_FRAMES)) begin
          req_rst_d   = 1'b1;
          rst_armed_d = 1'b0;
        end
      end else begin
        rst_hold_d  = '0;
        rst_armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      data_sync_q <= '0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      tmo_q       <= '0;
      pad_q       <= '0;
      pad_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      rst_hold_q  <= '0;
      rst_armed_q <= 1'b1;
      req_rst_q   <= 1'b0;
    end else begin
      data_sync_q <= data_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tmo_q       <= tmo_d;
      pad_q       <= pad_d;
      pad_valid_q <= pad_valid_d;
      frame_err_q <= frame_err_d;
      rst_hold_q  <= rst_hold_d;
      rst_armed_q <= rst_armed_d;
      req_rst_q   <= req_rst_d;
    end
  end

`ifdef PAD_REGION_COMBO_EN
  logic [HoldW-1:0] reg_hold_q, reg_hold_d;
  logic             reg_armed_q, reg_armed_d;
  logic             force_q, force_d;

  always_comb begin
    reg_hold_d  = reg_hold_q;
    reg_armed_d = reg_armed_q;
    force_d     = force_q;
    if (pad_valid_d) begin
      if (combo_hit(pad_d, ComboRegion)) begin
        if (reg_hold_q < HoldW'(HOLD_FRAMES)) reg_hold_d = reg_hold_q + HoldW'(1);
        if (reg_armed_q && reg_hold_d == HoldW'(HOLD_FRAMES)) begin
          force_d     = ~force_q;
          reg_armed_d = 1'b0;
        end
      end else begin
        reg_hold_d  = '0;
        reg_armed_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_i or negedge NRST_i) begin
    if (!NRST_i) begin
      reg_hold_q  <= '0;
      reg_armed_q <= 1'b1;
      force_q     <= 1'b0;
    end else begin
      reg_hold_q  <= reg_hold_d;
      reg_armed_q <= reg_armed_d;
      force_q     <= force_d;
    end
  end

  assign FORCE_REGION_o = force_q;
`else
  assign FORCE_REGION_o = 1'b0;
`endif

  assign pad_o       = pad_q;
  assign pad_valid_o = pad_valid_q;
  assign frame_err_o = frame_err_q;
  assign REQ_RST_o   = req_rst_q;

endmodule

// File: tb/tb_snes_pad_sniffer.sv
// Randomized bench for snes_pad_sniffer against a frame-level reference model.
module tb_snes_pad_sniffer;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned TimeoutCyc = 1024;
  localparam int unsigned HoldFrames = 60;
  localparam int unsigned Half       = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        latch = 1'b0;
  logic        pclk = 1'b1;
  logic        sdata = 1'b1;
  logic [15:0] pad;
  logic        pad_valid, frame_err, req_rst, force_region;

  always #5 clk = ~clk;

  snes_pad_sniffer #(
    .SYNC_STAGES (SyncStages),
    .TIMEOUT_CYC (TimeoutCyc),
    .HOLD_FRAMES (HoldFrames)
  ) dut (
    .CLK_i          (clk),
    .NRST_i         (rst_n),
    .CTRL_LATCH_i   (latch),
    .CTRL_CLK_i     (pclk),
    .CTRL_SDATA_i   (sdata),
    .pad_o          (pad),
    .pad_valid_o    (pad_valid),
    .frame_err_o    (frame_err),
    .REQ_RST_o      (req_rst),
    .FORCE_REGION_o (force_region)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Observed strobe counts.
  int n_valid = 0;
  int n_err = 0;
  int n_req = 0;

  // Reference model state.
  int          exp_valid = 0;
  int          exp_err = 0;
  int          exp_req = 0;
  logic [15:0] exp_pad = '0;
  logic        exp_force = 1'b0;
  int          rst_streak = 0;
  int          reg_streak = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pad_valid) n_valid++;
      if (frame_err) n_err++;
      if (req_rst) n_req++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Latch pulse (bit 0 valid at its fall) followed by nedges rising port-clock edges.
  task automatic send_bits(input logic [31:0] pins, input int nedges);
    pclk  = 1'b1;
    sdata = pins[0];
    latch = 1'b1;
    wait_cyc(4);
    latch = 1'b0;
    wait_cyc(Half);
    for (int k = 1; k <= nedges; k++) begin
      pclk  = 1'b0;
      sdata = pins[k];
      wait_cyc(Half);
      pclk = 1'b1;
      if (k != nedges) wait_cyc(Half);
    end
  endtask

  // Frame-level rules: ID nibble zero means valid; a combo fires on its HoldFrames-th
  // consecutive valid match and never again until the streak is broken.
  task automatic model_frame(input logic [15:0] val);
    if (val[15:12] == 4'h0) begin
      exp_valid++;
      exp_pad = val;
      if (val[11:0] == 12'h0C0C) begin
        rst_streak++;
        if (rst_streak == HoldFrames) exp_req++;
      end else begin
        rst_streak = 0;
      end
      if (val[11:0] == 12'h0C06) begin
        reg_streak++;
`ifdef PAD_REGION_COMBO_EN
        if (reg_streak == HoldFrames) exp_force = ~exp_force;
`endif
      end else begin
        reg_streak = 0;
      end
    end else begin
      exp_err++;
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "/valid_cnt"}, n_valid, exp_valid);
    check_eq({tag, "/err_cnt"}, n_err, exp_err);
    check_eq({tag, "/req_cnt"}, n_req, exp_req);
    check_eq({tag, "/pad"}, {16'd0, pad}, {16'd0, exp_pad});
    check_eq({tag, "/force"}, {31'd0, force_region}, {31'd0, exp_force});
  endtask

  task automatic full_frame(input string tag, input logic [3:0] idv, input logic [11:0] btn,
                            input int nedges);
    logic [31:0] pins;
    pins = {$urandom(), ~idv, ~btn};
    pins[15:0] = ~{idv, btn};
    send_bits(pins, nedges);
    wait_cyc(12);
    model_frame({idv, btn});
    check_state(tag);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] pins;

    wait_cyc(5);
    check_eq("reset/pad", {16'd0, pad}, 32'd0);
    check_eq("reset/valid", {31'd0, pad_valid}, 32'd0);
    check_eq("reset/err", {31'd0, frame_err}, 32'd0);
    check_eq("reset/req", {31'd0, req_rst}, 32'd0);
    check_eq("reset/force", {31'd0, force_region}, 32'd0);
    rst_n = 1'b1;
    wait_cyc(4);

    // B+Start with strobe latency after the 16th edge.
    pins = 32'hFFFF_FFF6;
    send_bits(pins, 15);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pad_valid) lat = i;
    end
    check_eq("bstart/latency", lat, SyncStages + 3);
    wait_cyc(10);
    model_frame(16'h0009);
    check_state("bstart");

    // Bad ID nibble.
    full_frame("bad_id", 4'hF, 12'h123, 15);

    // Latch re-asserted after 7 edges.
    send_bits($urandom(), 7);
    exp_err++;
    full_frame("relatch", 4'h0, 12'($urandom_range(0, 4095)), 15);

    // Latch rise coincident with a clock rise: the latch wins.
    send_bits($urandom(), 5);
    pclk = 1'b0;
    wait_cyc(Half);
    exp_err++;
    full_frame("coincide", 4'h0, 12'($urandom_range(0, 4095)), 15);

    // Clock stalls after bit 9.
    send_bits($urandom(), 9);
    wait_cyc(TimeoutCyc - 40);
    check_eq("tmo/early", n_err, exp_err);
    wait_cyc(60);
    exp_err++;
    check_eq("tmo/err", n_err, exp_err);
    check_eq("tmo/pad", {16'd0, pad}, {16'd0, exp_pad});
    full_frame("after_tmo", 4'h0, 12'($urandom_range(0, 4095)), 15);
    full_frame("edges32", 4'h0, 12'($urandom_range(0, 4095)), 31);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] idv;
      idv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      full_frame("random", idv, 12'($urandom_range(0, 4095)), 15);
    end

    // Reset combo: fires once at 60, silent for 100 more, again after a release.
    for (int i = 0; i < HoldFrames + 100; i++) begin
      if (i == 30) begin
        send_bits($urandom(), 4);
        wait_cyc(TimeoutCyc + 20);
        exp_err++;
      end
      full_frame("rst_hold", 4'h0, 12'h0C0C, 15);
    end
    full_frame("rst_release", 4'h0, 12'h0C00, 15);
    for (int i = 0; i < HoldFrames; i++) full_frame("rst_rehold", 4'h0, 12'h0C0C, 15);

    // Region combo: toggles 0->1, then 1->0 after a release.
    for (int i = 0; i < HoldFrames; i++) full_frame("reg_hold", 4'h0, 12'h0C06, 15);
    full_frame("reg_release", 4'h0, 12'h0C04, 15);
    for (int i = 0; i < HoldFrames; i++) full_frame("reg_rehold", 4'h0, 12'h0C06, 15);

    // Reset mid-frame: back to reset state, no strobe.
    for (int i = 0; i < 10; i++) full_frame("pre_rst", 4'h0, 12'h0C06, 15);
    send_bits($urandom(), 10);
    #2 rst_n = 1'b0;
    wait_cyc(3);
    exp_pad = '0;
    exp_force = 1'b0;
    rst_streak = 0;
    reg_streak = 0;
    check_state("midrst");
    rst_n = 1'b1;
    wait_cyc(3);
    full_frame("post_rst", 4'h0, 12'($urandom_range(0, 4095)), 15);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
